vc_wrr_scheduler: RTL

Weighted round-robin scheduler between the VC0/VC1 virtual-channel FIFOs and the D0/D1 destination FIFOs of the PCIe QoS interconnect. Each cycle it picks at most one VC head word, pops it and forwards it to the destination FIFO selected by the word's destination bit. It honours destination back-pressure and runs an INIT/IDLE/ACTIVE/ERROR state machine that reports interconnect status.

---
 rtl/qos_pkg.sv | 21 ++
 rtl/wrr_arb2.sv | 36 +++
 rtl/vc_wrr_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/qos_pkg.sv
// Shared QoS interconnect definitions: scheduler state encoding, word layout
// and weight normalisation.
package qos_pkg;

    localparam int BW       = 6;
    localparam int WW       = 4;
    localparam int DEST_BIT = BW - 2;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

    // A zero weight would starve a VC forever, so it is promoted to 1.
    function automatic logic [WW-1:0] norm_w(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

endpackage

// File: rtl/wrr_arb2.sv
// Two-way weighted round-robin grant and credit update, purely combinational.
module wrr_arb2 #(
    parameter int WW = 4
) (
    input  logic [1:0]         elig,
    input  logic               ptr,
    input  logic [1:0][WW-1:0] cred,
    input  logic [1:0][WW-1:0] w,
    output logic [1:0]         grant,
    output logic               ptr_nxt,
    output logic [1:0][WW-1:0] cred_nxt
);
    localparam logic [WW-1:0] ONE = WW'(1);

    logic o;
    assign o = ~ptr;

    always_comb begin
        grant    = '0;
        ptr_nxt  = ptr;
        cred_nxt = cred;
        if (elig[ptr] && cred[ptr] != '0) begin
            grant[ptr]    = 1'b1;
            cred_nxt[ptr] = cred[ptr] - ONE;
        end else if (elig[o]) begin
            // Handing over to the other VC starts a fresh burst for it.
            grant[o]    = 1'b1;
            ptr_nxt     = o;
            cred_nxt[o] = w[o] - ONE;
        end else if (elig[ptr]) begin
            grant[ptr]    = 1'b1;
            cred_nxt[ptr] = w[ptr] - ONE;
        end
    end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// VC0/VC1 to D0/D1 weighted round-robin scheduler with INIT/IDLE/ACTIVE/ERROR
// status FSM, one-cycle registered push path and per-VC served counters.
module vc_wrr_scheduler
    import qos_pkg::*;
#(
    parameter int BW = qos_pkg::BW,
    parameter int WW = qos_pkg::WW,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic [WW-1:0] weight_vc0,
    input  logic [WW-1:0] weight_vc1,
    input  logic          VC0_empty,
    input  logic          VC1_empty,
    input  logic [BW-1:0] VC0_data_out,
    input  logic [BW-1:0] VC1_data_out,
    input  logic          D0_almost_full,
    input  logic          D1_almost_full,
    input  logic          err_in,
    output logic          VC0_rd,
    output logic          VC1_rd,
    output logic          D0_wr,
    output logic          D1_wr,
    output logic [BW-1:0] D_data_in,
    output logic          idle_out,
    output logic          active_out,
    output logic          error_out,
    output logic [CW-1:0] vc0_served,
    output logic [CW-1:0] vc1_served
);
    state_t             state;
    logic               ptr;
    logic [1:0][WW-1:0] cred, w;
    logic [1:0]         elig, grant;
    logic               ptr_nxt;
    logic [1:0][WW-1:0] cred_nxt;
    logic               serve;

    // err_in and init gate the grant combinationally in the cycle they appear.
    assign serve = (state == IDLE || state == ACTIVE) && !init && !err_in;

    assign elig[0] = serve && !VC0_empty &&
                     !(VC0_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full);
    assign elig[1] = serve && !VC1_empty &&
                     !(VC1_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full);

    wrr_arb2 #(.WW(WW)) u_arb (
        .elig     (elig),
        .ptr      (ptr),
        .cred     (cred),
        .w        (w),
        .grant    (grant),
        .ptr_nxt  (ptr_nxt),
        .cred_nxt (cred_nxt)
    );

    assign VC0_rd     = grant[0];
    assign VC1_rd     = grant[1];
    assign idle_out   = (state == IDLE);
    assign active_out = (state == ACTIVE);
    assign error_out  = (state == ERROR);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= INIT;
            ptr        <= 1'b0;
            cred       <= '0;
            w          <= '0;
            D0_wr      <= 1'b0;
            D1_wr      <= 1'b0;
            D_data_in  <= '0;
            vc0_served <= '0;
            vc1_served <= '0;
        end else begin
            D0_wr <= 1'b0;
            D1_wr <= 1'b0;
            if (err_in) begin
                state <= ERROR;
            end else begin
                case (state)
                    INIT: begin
                        w[0]       <= norm_w(weight_vc0);
                        w[1]       <= norm_w(weight_vc1);
                        cred[0]    <= norm_w(weight_vc0);
                        cred[1]    <= norm_w(weight_vc1);
                        ptr        <= 1'b0;
                        vc0_served <= '0;
                        vc1_served <= '0;
                        if (!init) state <= IDLE;
                    end
                    IDLE, ACTIVE: begin
                        if (init) begin
                            state <= INIT;
                        end else begin
                            ptr   <= ptr_nxt;
                            cred  <= cred_nxt;
                            state <= (|grant) ? ACTIVE : IDLE;
                            if (grant[0]) begin
                                D_data_in  <= VC0_data_out;
                                D0_wr      <= ~VC0_data_out[DEST_BIT];
                                D1_wr      <=  VC0_data_out[DEST_BIT];
                                vc0_served <= vc0_served + 1'b1;
                            end else if (grant[1]) begin
                                D_data_in  <= VC1_data_out;
                                D0_wr      <= ~VC1_data_out[DEST_BIT];
                                D1_wr      <=  VC1_data_out[DEST_BIT];
                                vc1_served <= vc1_served + 1'b1;
                            end
                        end
                    end
                    default: state <= ERROR;
                endcase
            end
        end
    end

endmodule
